sa_stream_sequencer: RTL
========================

// Module: sa_stream_sequencer
// PURPOSE
//  Sequences one job on the SIZE x SIZE systolic array of pipelined FP32 x int8 PEs.
//  Each job loads the weights, streams input vectors with a diagonal row skew,
//  drains the accumulation pipeline, then signals completion.
//  Sits between the accelerator control registers / input buffer and the PE array.
//  Datapath data never passes through this block; it only produces strobes and indices.
// PARAMETERS
//  SIZE        4   array dimension: PE rows = PE columns = SIZE
//  PE_LATENCY  4   per-PE latency from in/input_valid to out/output_valid, in cycles
//  ROWS_W      16  width of the input-vector count
//  (localparam ACC_LAT = SIZE*PE_LATENCY: latency from a row-0 input to its column-0 result)
// PORTS
//  clk              in   1          clock
//  resetn           in   1          synchronous, active-low reset
//  start            in   1          job request; accepted only in IDLE
//  num_rows         in   ROWS_W     number of input vectors; sampled when start is accepted
//  in_avail         in   1          input buffer holds at least one vector
//  busy             out  1          high in LOAD_W, STREAM and DRAIN
//  done             out  1          one-cycle pulse at job end
//  weight_load_en   out  1          shift one weight row into the array this cycle
//  weight_row_idx   out  $clog2(SIZE)  weight row being loaded
//  in_rd_en         out  1          pop one input vector this cycle
//  in_valid_mask    out  SIZE       per-PE-row input_valid; bit r = in_rd_en delayed r cycles
//  out_capture      out  SIZE       per-column result strobe
//  out_last         out  1          out_capture[SIZE-1] strobe of the final vector
//  perf_total       out  32         cycles spent busy (see CONFIGURATION)
//  perf_stall       out  32         STREAM cycles with in_avail=0 (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0. Row counter, skew register and drain register are cleared.
//   Reset asserted mid-job aborts the job: outputs are 0 on the cycle after the reset edge.
//   No done pulse is issued for the aborted job.
//  States and transitions:
//   IDLE   -> LOAD_W on start; num_rows is latched.
//   LOAD_W : SIZE cycles. weight_load_en=1; weight_row_idx counts 0..SIZE-1.
//            Goes to STREAM if num_rows!=0, otherwise to DONE.
//   STREAM : in_rd_en = in_avail. A stall (in_avail=0) inserts a bubble; the skew and drain
//            registers keep shifting. Moves to DRAIN on the cycle after the num_rows-th pop.
//   DRAIN  : waits for out_last, then moves to DONE.
//   DONE   : done=1 and busy=0 for exactly 1 cycle, then IDLE.
//  start is ignored outside IDLE, including the DONE cycle.
//  num_rows changes after acceptance are ignored.
//  Timing: if vector k is popped at cycle t,
//   in_valid_mask[r] is high at cycle t+r;
//   out_capture[c] is high at cycle t+c+ACC_LAT.
//   Use shift registers of length SIZE-1+ACC_LAT. Never recompute timing from counters.
//  out_last coincides with out_capture[SIZE-1] for vector num_rows-1.
//  Bubbles propagate unchanged to out_capture. No output strobe occurs without a matching pop.
//  Row counter is ROWS_W bits and never wraps. num_rows = 2^ROWS_W-1 is legal.
//  Simultaneous in_avail rise and the final pop: exactly num_rows pops occur, never num_rows+1.
// CONFIGURATION
//  SA_SEQ_PERF_CNT_EN defined:
//   perf_total and perf_stall are 32-bit saturating counters.
//   Both clear when start is accepted; otherwise they hold their value.
//   perf_total increments each cycle that busy=1.
//   perf_stall increments each STREAM cycle with in_avail=0.
//   Values remain readable in IDLE.
//  SA_SEQ_PERF_CNT_EN not defined: perf_total=perf_stall=0 constantly. No counter flops exist.
// TESTING  (SIZE=4, PE_LATENCY=4 -> ACC_LAT=16; start high only in cycle 0)
//  1 num_rows=3, in_avail=1
//    -> weight_load_en cycles 1-4, weight_row_idx 0,1,2,3; in_rd_en 5-7
//    -> in_valid_mask[3] 8-10; out_capture[0] 21-23; out_capture[3] 24-26
//    -> out_last 26; done 27; busy 1-26
//  2 num_rows=0 -> weight_load_en 1-4; done 5; in_rd_en and out_capture never high
//  3 num_rows=2, in_avail=0 in cycle 6 only
//    -> in_rd_en 5,7; out_capture[0] 21,23; out_last 26; done 27; perf_stall=1 (macro on)
//  4 start pulsed again in cycles 3, 15 and 27 of test 1
//    -> ignored, single done; a start in cycle 28 begins a new job
//  5 resetn=0 in cycle 18 of test 1
//    -> all outputs 0 from 19; no done; a start in cycle 20 reproduces test 1 timing +20
//  6 macro on, test 1 -> perf_total=26, perf_stall=0; macro off -> both stay 0

Source files
------------

// File: rtl/sa_stream_sequencer_if.sv
// Handshake and strobe bundle between the job controller/input buffer and the sequencer.
// master = controller side, slave = sequencer side.
interface sa_stream_sequencer_if #(
  parameter int SIZE   = 4,
  parameter int ROWS_W = 16
);
  logic                    start;
  logic [ROWS_W-1:0]       num_rows;
  logic                    in_avail;
  logic                    busy;
  logic                    done;
  logic                    weight_load_en;
  logic [$clog2(SIZE)-1:0] weight_row_idx;
  logic                    in_rd_en;
  logic [SIZE-1:0]         in_valid_mask;
  logic [SIZE-1:0]         out_capture;
  logic                    out_last;
  logic [31:0]             perf_total;
  logic [31:0]             perf_stall;

  modport master (
    output start, num_rows, in_avail,
    input  busy, done, weight_load_en, weight_row_idx, in_rd_en,
           in_valid_mask, out_capture, out_last, perf_total, perf_stall
  );

  modport slave (
    input  start, num_rows, in_avail,
    output busy, done, weight_load_en, weight_row_idx, in_rd_en,
           in_valid_mask, out_capture, out_last, perf_total, perf_stall
  );
endinterface

// File: rtl/sa_stream_sequencer.sv
// Job sequencer for the SIZE x SIZE systolic array: weight load, skewed input stream, drain.
// Optional feature macro: SA_SEQ_PERF_CNT_EN enables the busy/stall performance counters.
module sa_stream_sequencer #(
  parameter int SIZE       = 4,
  parameter int PE_LATENCY = 4,
  parameter int ROWS_W     = 16
) (
  input logic                  clk,
  input logic                  resetn,
  sa_stream_sequencer_if.slave bus
);
  localparam int ACC_LAT = SIZE * PE_LATENCY;
  localparam int PIPE_LEN = SIZE - 1 + ACC_LAT;
  localparam int IDX_W = $clog2(SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t            state_reg;
  logic [ROWS_W-1:0] num_rows_reg;
  logic [ROWS_W-1:0] row_cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              wl_en_reg;
  logic [IDX_W-1:0]  w_idx_reg;
  logic              skew_reg [PIPE_LEN];
  logic              last_reg [PIPE_LEN];
  logic              in_rd_en;
  logic              final_pop;
  logic              out_last;

  // Only STREAM pops; num_rows_reg is nonzero whenever STREAM is reachable.
  assign in_rd_en  = (state_reg == STREAM) && bus.in_avail;
  assign final_pop = in_rd_en && (row_cnt_reg == num_rows_reg - ROWS_W'(1));
  assign out_last  = last_reg[PIPE_LEN-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      num_rows_reg <= '0;
      row_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      wl_en_reg    <= 1'b0;
      w_idx_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg    <= LOAD_W;
            num_rows_reg <= bus.num_rows;
            row_cnt_reg  <= '0;
            busy_reg     <= 1'b1;
            wl_en_reg    <= 1'b1;
            w_idx_reg    <= '0;
          end
        end
        LOAD_W: begin
          if (w_idx_reg == LAST_IDX) begin
            wl_en_reg <= 1'b0;
            w_idx_reg <= '0;
            if (num_rows_reg != '0) begin
              state_reg <= STREAM;
            end else begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else begin
            w_idx_reg <= w_idx_reg + IDX_W'(1);
          end
        end
        STREAM: begin
          if (in_rd_en) begin
            row_cnt_reg <= row_cnt_reg + ROWS_W'(1);
            if (final_pop) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_last) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Pop strobe and final-pop marker ride identical delay lines; bubbles shift through as zeros.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_LEN; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (!resetn) begin
          skew_reg[gi] <= 1'b0;
          last_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          skew_reg[gi] <= in_rd_en;
          last_reg[gi] <= final_pop;
        end else begin
          skew_reg[gi] <= skew_reg[(gi == 0) ? 0 : gi-1];
          last_reg[gi] <= last_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end

    for (gi = 0; gi < SIZE; gi++) begin : g_strobe
      if (gi == 0) begin : g_row0
        assign bus.in_valid_mask[gi] = in_rd_en;
      end else begin : g_rown
        assign bus.in_valid_mask[gi] = skew_reg[gi-1];
      end
      assign bus.out_capture[gi] = skew_reg[gi+ACC_LAT-1];
    end
  endgenerate

  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;
  assign bus.weight_load_en = wl_en_reg;
  assign bus.weight_row_idx = w_idx_reg;
  assign bus.in_rd_en       = in_rd_en;
  assign bus.out_last       = out_last;

`ifdef SA_SEQ_PERF_CNT_EN
  logic [31:0] perf_total_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_total_reg <= '0;
      perf_stall_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      perf_total_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (busy_reg && perf_total_reg != '1)
        perf_total_reg <= perf_total_reg + 32'd1;
      if (state_reg == STREAM && !bus.in_avail && perf_stall_reg != '1)
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign bus.perf_total = perf_total_reg;
  assign bus.perf_stall = perf_stall_reg;
`else
  assign bus.perf_total = '0;
  assign bus.perf_stall = '0;
`endif
endmodule
